// File: rtl/segdisp_pkg.sv
// Shared definitions for the four-digit seven-segment scan controller:
// scan states, digit/segment widths and the hex-to-segment lookup table.
package segdisp_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    DRIVE = 2'd1,
    BLANK = 2'd2
  } scan_state_t;

  localparam int NUM_DIGITS = 4;
  localparam int IDX_W      = 2;
  localparam int DIGIT_W    = 5;
  localparam int SEG_W      = 8;

  localparam logic [SEG_W-1:0]      SEG_OFF = 8'hFF;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = 4'hF;

  // Active-low {dp,g,f,e,d,c,b,a} patterns for hex 0..F, decimal point off.
  // Entry [15] is written first, entry [0] last.
  localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  // Active-low one-hot anode select for a digit index.
  function automatic logic [NUM_DIGITS-1:0] anode_sel(input logic [IDX_W-1:0] idx);
    return ~(NUM_DIGITS'(1) << idx);
  endfunction

endpackage

// File: rtl/segdisp_scan_ctrl_if.sv
// Bus bundle between a host and the display scan controller: scan enable,
// digit write port, digit readback port and the registered display pins.
interface segdisp_scan_ctrl_if;
  import segdisp_pkg::*;

  logic                  en;
  logic                  wr_en;
  logic [IDX_W-1:0]      wr_addr;
  logic [DIGIT_W-1:0]    wr_data;
  logic [IDX_W-1:0]      rd_addr;
  logic [DIGIT_W-1:0]    rd_data;
  logic [SEG_W-1:0]      seg_n;
  logic [NUM_DIGITS-1:0] an_n;
  logic                  frame_done;

  modport master (
    output en, wr_en, wr_addr, wr_data, rd_addr,
    input  rd_data, seg_n, an_n, frame_done
  );

  modport slave (
    input  en, wr_en, wr_addr, wr_data, rd_addr,
    output rd_data, seg_n, an_n, frame_done
  );

endinterface

// File: rtl/segdisp_hex_decoder.sv
// Purely combinational {dp,hex} to active-low segment pattern decoder.
module segdisp_hex_decoder
  import segdisp_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [SEG_W-1:0]   seg_n
);

  // Table lookup for the hex value; a set dp bit lights the decimal point.
  always_comb begin
    seg_n = SEG_TABLE[digit[3:0]];
    if (digit[DIGIT_W-1]) begin
      seg_n[SEG_W-1] = 1'b0;
    end
  end

endmodule

// File: rtl/segdisp_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller. The host writes a
// shadow bank at any time; the displayed (active) bank is refreshed from the
// shadow bank only at the frame boundary so a frame never shows a mix of old
// and new digits. Each digit is driven for DIGIT_CYC cycles, followed by
// BLANK_CYC cycles with every anode off to avoid ghosting.
module segdisp_scan_ctrl
  import segdisp_pkg::*;
#(
  parameter int DIGIT_CYC = 50000,
  parameter int BLANK_CYC = 8
) (
  input logic HCLK,
  input logic HRESET,
  segdisp_scan_ctrl_if.slave bus
);

  localparam int MAX_CYC = (DIGIT_CYC > BLANK_CYC) ? DIGIT_CYC : BLANK_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(DIGIT_CYC - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);

  scan_state_t state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             frame_copy;

  logic [DIGIT_W-1:0] shadow [NUM_DIGITS];
  logic [DIGIT_W-1:0] active [NUM_DIGITS];

  logic                  drive_nxt;
  logic [DIGIT_W-1:0]    show_digit;
  logic [SEG_W-1:0]      show_seg_n;
  logic [SEG_W-1:0]      seg_n_q;
  logic [NUM_DIGITS-1:0] an_n_q;
  logic                  frame_done_q;

  // Scan state, digit index and dwell counter registers.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state <= OFF;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic; dropping en always wins and parks the scan at digit 0.
  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    cnt_nxt    = cnt;
    frame_copy = 1'b0;
    if (!bus.en) begin
      state_nxt = OFF;
      idx_nxt   = '0;
      cnt_nxt   = '0;
    end else begin
      unique case (state)
        OFF: begin
          state_nxt = DRIVE;
          idx_nxt   = '0;
          cnt_nxt   = '0;
        end
        DRIVE: begin
          if (cnt == DIGIT_LAST) begin
            state_nxt = BLANK;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            state_nxt  = DRIVE;
            idx_nxt    = idx + 1'b1;
            cnt_nxt    = '0;
            frame_copy = (idx == LAST_IDX);
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        default: begin
          state_nxt = OFF;
          idx_nxt   = '0;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // The registered outputs reflect the state being entered, so the digit shown
  // on the copy edge must come from the shadow bank that is being copied.
  assign drive_nxt  = (state_nxt == DRIVE);
  assign show_digit = frame_copy ? shadow[idx_nxt] : active[idx_nxt];

  segdisp_hex_decoder u_decoder (
    .digit (show_digit),
    .seg_n (show_seg_n)
  );

  // Display pin and frame pulse registers, all dark while not driving.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      an_n_q       <= AN_OFF;
      seg_n_q      <= SEG_OFF;
      frame_done_q <= 1'b0;
    end else begin
      an_n_q       <= drive_nxt ? anode_sel(idx_nxt) : AN_OFF;
      seg_n_q      <= drive_nxt ? show_seg_n : SEG_OFF;
      frame_done_q <= frame_copy;
    end
  end

  // Shadow bank takes host writes unconditionally, whatever the scan is doing.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow[i] <= '0;
      end
    end else if (bus.wr_en) begin
      shadow[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Active bank snapshots the pre-write shadow bank at the frame boundary.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        active[i] <= '0;
      end
    end else if (frame_copy) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        active[i] <= shadow[i];
      end
    end
  end

  assign bus.rd_data    = shadow[bus.rd_addr];
  assign bus.an_n       = an_n_q;
  assign bus.seg_n      = seg_n_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_segdisp_scan_ctrl.sv
// Self-checking bench for segdisp_scan_ctrl with short dwell times: directed
// scenarios with literal expectations, then randomized traffic checked every
// cycle against a frame-position model of the display.
module tb_segdisp_scan_ctrl;

  localparam int D      = 4;
  localparam int B      = 2;
  localparam int SLOT   = D + B;
  localparam int PERIOD = 4 * SLOT;

  logic HCLK;
  logic HRESET;

  segdisp_scan_ctrl_if bus ();

  segdisp_scan_ctrl #(
    .DIGIT_CYC (D),
    .BLANK_CYC (B)
  ) dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  // Reference model: where in the frame the display is, plus both banks.
  int         m_pos;
  bit         m_on;
  bit         m_fd;
  logic [4:0] m_shadow [4];
  logic [4:0] m_active [4];
  logic [4:0] m_pre    [4];

  int         ph;
  int         dg;
  logic [3:0] e_an;
  logic [7:0] e_seg;
  logic [3:0] exp_an_seq [7];
  int         cyc;

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  // Reference segment pattern built from the lit-segment (active-high) form.
  function automatic logic [7:0] refSegments(input logic [4:0] d);
    logic [6:0] lit;
    case (d[3:0])
      4'h0: lit = 7'h3F;  4'h1: lit = 7'h06;  4'h2: lit = 7'h5B;  4'h3: lit = 7'h4F;
      4'h4: lit = 7'h66;  4'h5: lit = 7'h6D;  4'h6: lit = 7'h7D;  4'h7: lit = 7'h07;
      4'h8: lit = 7'h7F;  4'h9: lit = 7'h6F;  4'hA: lit = 7'h77;  4'hB: lit = 7'h7C;
      4'hC: lit = 7'h39;  4'hD: lit = 7'h5E;  4'hE: lit = 7'h79;  default: lit = 7'h71;
    endcase
    return {~d[4], ~lit};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic en_v, input logic wr_en_v,
                               input logic [1:0] wa, input logic [4:0] wd,
                               input logic [1:0] ra);
    bus.en      = en_v;
    bus.wr_en   = wr_en_v;
    bus.wr_addr = wa;
    bus.wr_data = wd;
    bus.rd_addr = ra;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge HCLK);
      #1;
    end
  endtask

  // Model update: frame position advances while enabled; wrap means copy.
  always @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      m_pos = 0;
      m_on  = 1'b0;
      m_fd  = 1'b0;
      for (int i = 0; i < 4; i++) begin
        m_shadow[i] = 5'h00;
        m_active[i] = 5'h00;
      end
    end else begin
      m_pre = m_shadow;
      m_fd  = 1'b0;
      if (bus.wr_en) m_shadow[bus.wr_addr] = bus.wr_data;
      if (!bus.en) begin
        m_on  = 1'b0;
        m_pos = 0;
      end else if (!m_on) begin
        m_on  = 1'b1;
        m_pos = 0;
      end else begin
        m_pos = (m_pos + 1) % PERIOD;
        if (m_pos == 0) begin
          m_active = m_pre;
          m_fd     = 1'b1;
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge HCLK) begin
    if (check_en) begin
      ph = m_pos % SLOT;
      dg = m_pos / SLOT;
      if (m_on && ph < D) begin
        e_an  = ~(4'b0001 << dg);
        e_seg = refSegments(m_active[dg]);
      end else begin
        e_an  = 4'hF;
        e_seg = 8'hFF;
      end
      checkOutput("model_an_n", bus.an_n, e_an);
      checkOutput("model_seg_n", bus.seg_n, e_seg);
      checkOutput("model_frame_done", bus.frame_done, m_fd);
      checkOutput("model_rd_data", bus.rd_data, m_shadow[bus.rd_addr]);
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_an_seq[0] = 4'hE; exp_an_seq[1] = 4'hE; exp_an_seq[2] = 4'hE;
    exp_an_seq[3] = 4'hE; exp_an_seq[4] = 4'hF; exp_an_seq[5] = 4'hF;
    exp_an_seq[6] = 4'hD;

    HRESET = 1'b0;
    applyStimulus(1'b0, 1'b0, 2'd0, 5'h00, 2'd0);
    #1 HRESET = 1'b1;
    step(2);
    checkOutput("reset_an_n", bus.an_n, 4'hF);
    checkOutput("reset_seg_n", bus.seg_n, 8'hFF);
    checkOutput("reset_frame_done", bus.frame_done, 1'b0);
    for (int i = 0; i < 4; i++) begin
      bus.rd_addr = 2'(i);
      #1 checkOutput("reset_rd_data", bus.rd_data, 5'h00);
    end
    check_en = 1'b1;

    // First digit drives immediately after enable.
    HRESET = 1'b0;
    applyStimulus(1'b1, 1'b0, 2'd0, 5'h00, 2'd0);
    step(1);
    for (int k = 0; k < 7; k++) begin
      checkOutput("scan_an_n", bus.an_n, exp_an_seq[k]);
      if (k < 4) checkOutput("scan_seg_drive", bus.seg_n, 8'hC0);
      if (k == 4) checkOutput("scan_seg_blank", bus.seg_n, 8'hFF);
      step(1);
    end

    // Frame pulse position, width and period.
    cyc = 0;
    while (bus.frame_done !== 1'b1 && cyc < 100) begin
      step(1);
      cyc++;
    end
    checkOutput("fd_first_pos", cyc + 7, PERIOD);
    step(1);
    checkOutput("fd_width", bus.frame_done, 1'b0);
    cyc = 1;
    while (bus.frame_done !== 1'b1 && cyc < 100) begin
      step(1);
      cyc++;
    end
    checkOutput("fd_period", cyc, 24);

    // Mid-frame write to digit 2 shows only from the next frame.
    step(2);
    applyStimulus(1'b1, 1'b1, 2'd2, 5'h13, 2'd2);
    step(1);
    applyStimulus(1'b1, 1'b0, 2'd0, 5'h00, 2'd2);
    #1 checkOutput("rd_after_write", bus.rd_data, 5'h13);
    step(9);
    checkOutput("d2_an_n", bus.an_n, 4'hB);
    checkOutput("d2_old_seg", bus.seg_n, 8'hC0);
    step(24);
    checkOutput("d2_new_seg", bus.seg_n, 8'h30);

    // Write on the copy edge: old value for one more frame.
    step(11);
    applyStimulus(1'b1, 1'b1, 2'd1, 5'h08, 2'd0);
    step(1);
    applyStimulus(1'b1, 1'b0, 2'd0, 5'h00, 2'd0);
    checkOutput("copy_edge_fd", bus.frame_done, 1'b1);
    step(6);
    checkOutput("race_an_n", bus.an_n, 4'hD);
    checkOutput("race_old_seg", bus.seg_n, 8'hC0);
    step(24);
    checkOutput("race_new_seg", bus.seg_n, 8'h80);

    // Drop en while driving digit 1, then restart from digit 0.
    applyStimulus(1'b0, 1'b0, 2'd0, 5'h00, 2'd0);
    step(1);
    checkOutput("en_drop_an_n", bus.an_n, 4'hF);
    checkOutput("en_drop_seg_n", bus.seg_n, 8'hFF);
    step(3);
    applyStimulus(1'b1, 1'b0, 2'd0, 5'h00, 2'd0);
    step(1);
    for (int k = 0; k < 4; k++) begin
      checkOutput("reen_d0_an_n", bus.an_n, 4'hE);
      step(1);
    end
    checkOutput("reen_blank_an_n", bus.an_n, 4'hF);

    // Asynchronous reset during blanking clears the shadow bank at once.
    #1 HRESET = 1'b1;
    #1;
    checkOutput("rst_blank_an_n", bus.an_n, 4'hF);
    checkOutput("rst_blank_seg_n", bus.seg_n, 8'hFF);
    checkOutput("rst_blank_fd", bus.frame_done, 1'b0);
    for (int i = 0; i < 4; i++) begin
      bus.rd_addr = 2'(i);
      #1 checkOutput("rst_blank_rd_data", bus.rd_data, 5'h00);
    end
    step(2);
    checkOutput("rst_hold_fd", bus.frame_done, 1'b0);
    HRESET = 1'b0;
    applyStimulus(1'b0, 1'b0, 2'd0, 5'h00, 2'd0);
    step(2);
    checkOutput("idle_after_reset", bus.an_n, 4'hF);
    applyStimulus(1'b1, 1'b0, 2'd0, 5'h00, 2'd0);
    step(1);
    checkOutput("restart_d0_an_n", bus.an_n, 4'hE);

    // Asynchronous reset while a digit is lit darkens it before any edge.
    #1 HRESET = 1'b1;
    #1;
    checkOutput("rst_drive_an_n", bus.an_n, 4'hF);
    checkOutput("rst_drive_seg_n", bus.seg_n, 8'hFF);
    step(1);
    HRESET = 1'b0;

    // Randomized traffic with occasional enable drops and resets.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(1'($urandom_range(99) < 97), 1'($urandom_range(99) < 25),
                    2'($urandom_range(3)), 5'($urandom_range(31)),
                    2'($urandom_range(3)));
      HRESET = ($urandom_range(999) < 3) ? 1'b1 : 1'b0;
      step(1);
    end
    HRESET = 1'b0;
    step(2);

    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
